// File: rtl/hwag_wheel_sync.sv
// rtl/hwag_wheel_sync.sv - trigger-wheel synchroniser: tooth period capture, gap ratio test, hunt/confirm/sync tracking
module hwag_wheel_sync #(
    parameter int PCNT_WIDTH  = 24,
    parameter int TCNT_WIDTH  = 8,
    parameter int TEETH       = 60,
    parameter int MISSING     = 2,
    parameter int GAP_CONFIRM = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  edge_in,
    input  logic [PCNT_WIDTH-1:0] pmin,
    input  logic [PCNT_WIDTH-1:0] pmax,
    output logic [PCNT_WIDTH-1:0] period,
    output logic [TCNT_WIDTH-1:0] tooth_num,
    output logic                  synced,
    output logic                  gap_pulse,
    output logic                  sync_err,
    output logic                  stall,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_SYNC    = 2'd3
    } state_t;

    localparam logic [PCNT_WIDTH-1:0] PCNT_MAX   = '1;
    localparam logic [PCNT_WIDTH-1:0] PCNT_ONE   = PCNT_WIDTH'(1);
    localparam logic [TCNT_WIDTH-1:0] TOOTH_ONE  = TCNT_WIDTH'(1);
    localparam logic [TCNT_WIDTH-1:0] TOOTH_LAST = TCNT_WIDTH'(TEETH - MISSING - 1);
    localparam logic [2:0]            CFM_GOAL   = 3'(GAP_CONFIRM);

    state_t                  st, st_nxt;
    logic [PCNT_WIDTH-1:0]   pcnt, pcnt_nxt, p1, p1_nxt, p0, p0_nxt, period_nxt;
    logic [TCNT_WIDTH-1:0]   tooth_nxt;
    logic [2:0]              cfm_cnt, cfm_nxt;
    logic                    run, run_nxt, gap_pulse_nxt, sync_err_nxt;
    logic                    stall_take, p_valid, p1_valid, is_gap, gap_due;
    logic [PCNT_WIDTH:0]     gap_thresh;
    logic                    dbg_unused;

    // run marks that a reference edge has been seen, so pcnt measures a real interval
    assign stall      = (pcnt == PCNT_MAX);
    assign stall_take = stall && (st != ST_IDLE);
    assign state      = st;
    assign p_valid    = (pcnt >= pmin) && (pcnt <= pmax);
    assign p1_valid   = (p1 >= pmin) && (p1 <= pmax);
    assign gap_thresh = {1'b0, p1} + {2'b00, p1[PCNT_WIDTH-1:1]};
    assign is_gap     = p1_valid && ({1'b0, pcnt} > gap_thresh);
    assign gap_due    = (tooth_num == TOOTH_LAST);
    assign dbg_unused = ^p0;

    always_comb begin
        st_nxt        = st;
        pcnt_nxt      = pcnt;
        p1_nxt        = p1;
        p0_nxt        = p0;
        period_nxt    = period;
        tooth_nxt     = tooth_num;
        cfm_nxt       = cfm_cnt;
        run_nxt       = run;
        gap_pulse_nxt = 1'b0;
        sync_err_nxt  = 1'b0;
        if (run && (pcnt != PCNT_MAX)) begin
            pcnt_nxt = pcnt + PCNT_ONE;
        end
        if (stall_take) begin
            // edge arriving in the saturation cycle is dropped on purpose
            st_nxt       = ST_IDLE;
            run_nxt      = 1'b0;
            p1_nxt       = '0;
            p0_nxt       = '0;
            tooth_nxt    = '0;
            cfm_nxt      = '0;
            sync_err_nxt = synced;
        end else if (edge_in) begin
            pcnt_nxt   = PCNT_ONE;
            p1_nxt     = pcnt;
            p0_nxt     = p1;
            period_nxt = pcnt;
            run_nxt    = 1'b1;
            if (st == ST_IDLE) begin
                if (run && p_valid) begin
                    st_nxt = ST_HUNT;
                end
            end else if (!p_valid) begin
                sync_err_nxt = synced;
                st_nxt       = ST_IDLE;
                p1_nxt       = '0;
                tooth_nxt    = '0;
                cfm_nxt      = '0;
            end else if (st == ST_HUNT) begin
                tooth_nxt = '0;
                if (is_gap) begin
                    gap_pulse_nxt = 1'b1;
                    if (GAP_CONFIRM == 1) begin
                        st_nxt = ST_SYNC;
                    end else begin
                        st_nxt  = ST_CONFIRM;
                        cfm_nxt = 3'd1;
                    end
                end
            end else if (gap_due && is_gap) begin
                tooth_nxt     = '0;
                gap_pulse_nxt = 1'b1;
                if (st == ST_CONFIRM) begin
                    cfm_nxt = cfm_cnt + 3'd1;
                    if (cfm_cnt + 3'd1 == CFM_GOAL) begin
                        st_nxt = ST_SYNC;
                    end
                end
            end else if (gap_due || is_gap) begin
                sync_err_nxt = (st == ST_SYNC);
                st_nxt       = ST_HUNT;
                tooth_nxt    = '0;
                cfm_nxt      = '0;
            end else begin
                tooth_nxt = tooth_num + TOOTH_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            st        <= ST_IDLE;
            pcnt      <= '0;
            p1        <= '0;
            p0        <= '0;
            period    <= '0;
            tooth_num <= '0;
            cfm_cnt   <= '0;
            run       <= 1'b0;
            synced    <= 1'b0;
            gap_pulse <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            st        <= st_nxt;
            pcnt      <= pcnt_nxt;
            p1        <= p1_nxt;
            p0        <= p0_nxt;
            period    <= period_nxt;
            tooth_num <= tooth_nxt;
            cfm_cnt   <= cfm_nxt;
            run       <= run_nxt;
            synced    <= (st_nxt == ST_SYNC);
            gap_pulse <= gap_pulse_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

endmodule
